// File: rtl/uart_transmitter_if.sv
// Byte-in / serial-out handshake bundle for the UART transmit stage.
// The producer drives data_in/data_valid; the transmitter drives the rest.
interface uart_transmitter_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       serial_out;
  logic       busy;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  serial_out,
    input  busy
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output serial_out,
    output busy
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmit stage: frames each accepted byte as start, 8 data bits MSB first,
// even parity and stop. A one-entry holding register lets the next frame start on
// the same edge the current stop bit ends. All outputs are registered.
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input logic           clk,
  input logic           rst,
  uart_transmitter_if.slave tx
);

  localparam logic [15:0] BaudMax = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [15:0] baud_q, baud_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_par_q, hold_par_d;
  logic        hold_full_q, hold_full_d;
  logic        serial_q, serial_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;

  logic        accept;
  logic        bit_end;
  logic        load_new;

  // A transfer needs the registered ready, so a byte can never arrive while
  // the holding register is full.
  assign accept  = tx.data_valid & ready_q;
  assign bit_end = (state_q != StIdle) && (baud_q == BaudMax);

  assign tx.data_ready = ready_q;
  assign tx.serial_out = serial_q;
  assign tx.busy       = busy_q;

  // State register; reset forces the line idle asynchronously and drops all bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      bit_idx_q   <= 3'd0;
      baud_q      <= 16'd0;
      hold_q      <= 8'h00;
      hold_par_q  <= 1'b0;
      hold_full_q <= 1'b0;
      serial_q    <= 1'b1;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      bit_idx_q   <= bit_idx_d;
      baud_q      <= baud_d;
      hold_q      <= hold_d;
      hold_par_q  <= hold_par_d;
      hold_full_q <= hold_full_d;
      serial_q    <= serial_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state: frame sequencing, byte routing (shifter vs holding register)
  // and the registered output values derived from the next state.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    bit_idx_d   = bit_idx_q;
    baud_d      = baud_q;
    hold_d      = hold_q;
    hold_par_d  = hold_par_q;
    hold_full_d = hold_full_q;
    load_new    = 1'b0;

    // Baud counter runs only while a frame is on the line.
    if (state_q == StIdle) begin
      baud_d = 16'd0;
    end else if (bit_end) begin
      baud_d = 16'd0;
    end else begin
      baud_d = baud_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          load_new = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = StParity;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {shift_q[6:0], 1'b0};
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (hold_full_q) begin
            // Held byte goes straight into the shifter: no idle gap.
            state_d     = StStart;
            shift_d     = hold_q;
            parity_d    = hold_par_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            load_new = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Parity is captured with the byte so later data_in changes cannot leak in.
    if (load_new) begin
      state_d  = StStart;
      shift_d  = tx.data_in;
      parity_d = ^tx.data_in;
    end else if (accept) begin
      hold_d      = tx.data_in;
      hold_par_d  = ^tx.data_in;
      hold_full_d = 1'b1;
    end
  end

  // Output values for the cycle following the next edge.
  always_comb begin
    serial_d = 1'b1;
    unique case (state_d)
      StIdle:   serial_d = 1'b1;
      StStart:  serial_d = 1'b0;
      StData:   serial_d = shift_d[7];
      StParity: serial_d = parity_d;
      StStop:   serial_d = 1'b1;
      default:  serial_d = 1'b1;
    endcase
    busy_d  = (state_d != StIdle);
    ready_d = ~hold_full_d;
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a reference model expands every accepted byte into
// its expected per-cycle line waveform; a monitor checks serial_out, busy and
// data_ready every cycle against that queue.
module tb_uart_transmitter;

  localparam int unsigned Cpb         = 3;
  localparam int unsigned FrameCycles = 11 * Cpb;

  logic clk = 1'b0;
  logic rst;

  uart_transmitter_if tx_if ();

  uart_transmitter #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx (tx_if)
  );

  always #5 clk = ~clk;

  bit exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic void check(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endfunction

  // Reference frame: start 0, data MSB first, even parity, stop 1; each bit Cpb cycles.
  function automatic void push_frame(logic [7:0] b);
    logic [10:0] f;
    f = {1'b0, b, ^b, 1'b1};
    for (int i = 10; i >= 0; i--) begin
      for (int c = 0; c < int'(Cpb); c++) begin
        exp_q.push_back(f[i]);
      end
    end
  endfunction

  // Monitor: one expected line bit per cycle; an empty queue means an idle line.
  // More than one outstanding frame means a byte is held, so ready must be low.
  always @(negedge clk) begin : monitor
    int n;
    bit b;
    if (rst) begin
      check("rst_serial", tx_if.serial_out, 1'b1);
      check("rst_busy", tx_if.busy, 1'b0);
      check("rst_ready", tx_if.data_ready, 1'b1);
    end else begin
      n = exp_q.size();
      check("data_ready", tx_if.data_ready, ((n + int'(FrameCycles) - 1) / int'(FrameCycles)) < 2);
      if (n > 0) begin
        b = exp_q.pop_front();
        check("serial_out", tx_if.serial_out, b);
        check("busy", tx_if.busy, 1'b1);
      end else begin
        check("idle_serial", tx_if.serial_out, 1'b1);
        check("idle_busy", tx_if.busy, 1'b0);
      end
    end
  end

  // Present a byte and hold it until accepted; called and returns at posedge+1.
  task automatic send(input logic [7:0] b);
    bit acc;
    acc = 1'b0;
    tx_if.data_in    = b;
    tx_if.data_valid = 1'b1;
    for (int i = 0; i < 3 * int'(FrameCycles) && !acc; i++) begin
      @(negedge clk);
      if (tx_if.data_ready) acc = 1'b1;
    end
    check("accepted", acc, 1'b1);
    if (acc) begin
      @(posedge clk);
      push_frame(b);
    end
    #1;
    tx_if.data_valid = 1'b0;
    tx_if.data_in    = 8'($urandom);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * int'(FrameCycles) && exp_q.size() != 0; i++) @(posedge clk);
    check("drained", exp_q.size() == 0, 1'b1);
    #1;
  endtask

  initial begin
    rst              = 1'b1;
    tx_if.data_in    = 8'h00;
    tx_if.data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    idle(20);

    // Single frames from idle.
    send(8'hA5);
    drain();
    idle(3);
    send(8'h07);
    drain();
    idle(3);

    // Back-to-back burst with valid held high.
    send(8'h00);
    send(8'hFF);
    send(8'h3C);
    drain();
    idle(4);

    // Reset during data bit 4 of 0xF0 with a second byte held.
    send(8'hF0);
    send(8'h5A);
    repeat (5 * Cpb - 1) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_serial", tx_if.serial_out, 1'b1);
    check("async_busy", tx_if.busy, 1'b0);
    check("async_ready", tx_if.data_ready, 1'b1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    idle(2 * FrameCycles);

    // Random bytes with random gaps, including zero-gap back-to-back runs.
    for (int k = 0; k < 256; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      send(8'($urandom));
      if (gap > 0) idle(gap);
    end
    drain();
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit stage of the UART link: accepts parallel bytes over a valid/ready handshake and emits framed serial data on one wire. Frame: start, 8 data bits MSB first, even parity, stop. It sits directly upstream of the UART receive stage and drives that stage's serial input. A one-entry holding register allows frames to be sent back-to-back with no idle gap.

## Interface
- CLKS_PER_BIT, default 1: clock cycles per serial bit period; legal range 1..65535.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  8  byte to transmit; sampled only on an accepted transfer.
- data_valid  input  1  producer has a byte on data_in.
- data_ready  output  1  block can accept a byte this cycle.
- serial_out  output  1  serial line; idle level 1.
- busy  output  1  a frame is being shifted out.

## Operation
- Reset values: serial_out=1, busy=0, data_ready=1, holding register empty, state IDLE, bit counter 0, baud counter 0.
- Transfer occurs on a rising edge where data_valid=1 and data_ready=1.
- data_ready = not(holding register full). It is a registered output.
- Accepted byte routing:
  - If the shifter is idle, or finishes its stop bit on the same edge, and the holding register is empty, the byte loads directly into the shifter.
  - Otherwise the byte goes into the holding register.
- States:
  - IDLE: serial_out=1. Leaves to START when the shifter loads.
  - START: serial_out=0 for one bit period, then DATA.
  - DATA: serial_out=shift[7], MSB first, for 8 bit periods. The bit index counts 0..7; after index 7 go to PARITY.
  - PARITY: serial_out = XOR of the 8 data bits (even parity: ones in data plus parity is even), for one bit period, then STOP.
  - STOP: serial_out=1 for one bit period. At the end, if the holding register is full, move it into the shifter, clear the holding register and go to START; else go to IDLE.
- Parity is computed from the byte at load time and stored with it. Later changes on data_in have no effect.
- Baud counter counts 0..CLKS_PER_BIT-1 in every non-IDLE state. A bit period ends when the counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
- busy=1 in START, DATA, PARITY and STOP; busy=0 in IDLE.
- data_valid while data_ready=0 is ignored. The producer must hold data_in until it is accepted.
- Reset asserted mid-frame: all state returns to reset values immediately, and serial_out goes to 1 asynchronously. The in-flight byte and the held byte are discarded.

## Timing
- All outputs are registered. Only rst affects outputs asynchronously.
- Latency: a byte accepted at edge k from IDLE drives the start bit on serial_out from edge k until edge k+CLKS_PER_BIT.
- Frame length is exactly 11*CLKS_PER_BIT cycles.
- Back-to-back: with the holding register full, the next start bit begins on the same edge that the stop bit ends. There are no idle cycles between frames.
- data_ready:
  - Falls on the edge that fills the holding register.
  - Rises on the edge the held byte moves into the shifter.
  - On that same edge a new transfer cannot occur, because data_ready was 0 during the preceding cycle.
- Maximum sustained throughput: one byte per 11*CLKS_PER_BIT cycles.

## Test plan
- Reset then idle 20 cycles -> serial_out=1, busy=0, data_ready=1 throughout.
- CLKS_PER_BIT=1, send 0xA5 from IDLE -> serial_out over 11 cycles: 0,1,0,1,0,0,1,0,1,0,1 (parity 0). busy high 11 cycles, then IDLE.
- CLKS_PER_BIT=4, send 0x07 -> each bit held 4 cycles; sequence 0,0,0,0,0,0,1,1,1,1,1 (parity 1); frame is 44 cycles.
- CLKS_PER_BIT=1, present 0x00, 0xFF, 0x3C with data_valid held high:
  - data_ready drops after the second byte.
  - Three contiguous 11-bit frames with parities 0,0,0.
  - No idle bit between frames.
  - The third byte is accepted only after the second moves into the shifter.
- Assert rst during DATA bit 4 of 0xF0 with a byte held -> serial_out=1 and busy=0 immediately. After release, line idle; no residual frame.
- Loopback of serial_out into the UART receive stage for 256 random bytes -> every byte recovered, parity error and stop error never asserted.
